// File: rtl/demux_nb_1_n_seq_pkg.sv
// demux_nb_1_n_seq_pkg
// Shared types and helpers for the 1-to-N non-blocking sequential demux.
//   mode_e    : routing mode (manual by sel / auto-scan by internal pointer)
//   ACC_W     : width of the accepted-word counter
//   sel_width : select width for a channel count, never below 1 bit
`include "demux_defs.vh"

package demux_nb_1_n_seq_pkg;

  typedef enum logic {
    MODE_MANUAL_E = `MODE_MANUAL,
    MODE_AUTO_E   = `MODE_AUTO
  } mode_e;

  localparam int ACC_W = 8;

  function automatic int sel_width(input int ch);
    return (ch <= 2) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/demux_defs.vh
// demux_defs.vh
// Mode encodings for the 1-to-N demultiplexer, shared by the RTL and its bench.
`ifndef DEMUX_DEFS_VH
`define DEMUX_DEFS_VH

`define MODE_MANUAL 1'b0
`define MODE_AUTO   1'b1

`endif

// File: rtl/demux_slot.sv
// demux_slot
// One-word output slot: a data register plus a full flag.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low clear (flag and data to 0)
//   load  : write data into the slot this edge (sets full)
//   data  : word to store
//   drain : consumer takes the word this edge (clears full unless loading)
//   full  : slot holds an unconsumed word
//   q     : stored word; keeps its last value after a drain
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] q
);

  logic             full_reg, full_next;
  logic [WIDTH-1:0] data_reg, data_next;

  // A load wins over a drain: the old word leaves and the new one lands on
  // the same edge, so the slot stays full with no loss or duplication.
  always_comb begin
    full_next = full_reg;
    data_next = data_reg;
    if (load) begin
      full_next = 1'b1;
      data_next = data;
    end else if (drain) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else begin
      full_reg <= full_next;
      data_reg <= data_next;
    end
  end

  assign full = full_reg;
  assign q    = data_reg;

endmodule

// File: rtl/demux_nb_1_n_seq.sv
// demux_nb_1_n_seq
// 1-to-N demultiplexer with a one-word slot per output channel and
// ready/valid handshakes on both sides.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous assert, internally synchronised release
//   mode     : 0 = route by sel, 1 = route by internal scan pointer
//   sel      : manual-mode target channel
//   d        : input word, in_valid qualifies it
//   in_ready : target slot can take d this cycle
//   y        : channel i data at [i*WIDTH +: WIDTH]
//   y_valid  : channel i holds an unconsumed word
//   y_ready  : consumer i takes its word this cycle
//   cur_ch   : target channel in effect this cycle
//   acc_cnt  : count of accepted words, wraps at 256
module demux_nb_1_n_seq
  import demux_nb_1_n_seq_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [WIDTH-1:0]          d,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] y,
  output logic [CHANNELS-1:0]       y_valid,
  input  logic [CHANNELS-1:0]       y_ready,
  output logic [SEL_W-1:0]          cur_ch,
  output logic [ACC_W-1:0]          acc_cnt
);

  // Single-stage release synchroniser: clears asynchronously with rst_n and
  // rises on the first edge after release, so the earliest accept lands on
  // the second edge. Its output is the reset for all other state.
  logic rst_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 1'b0;
    end else begin
      rst_sync_reg <= 1'b1;
    end
  end

  mode_e              mode_sel;
  logic [SEL_W-1:0]   tgt;
  logic               tgt_in_range;
  logic               tgt_full;
  logic               tgt_drain;
  logic               accept;
  logic [CHANNELS-1:0] load_vec;
  logic [CHANNELS-1:0] full_vec;

  logic [SEL_W-1:0] scan_ptr_reg, scan_ptr_next;
  logic [ACC_W-1:0] acc_cnt_reg, acc_cnt_next;

  assign mode_sel = mode_e'(mode);
  assign tgt      = (mode_sel == MODE_AUTO_E) ? scan_ptr_reg : sel;

  // sel can encode channels that do not exist when CHANNELS is not a power
  // of two; those targets are never ready.
  assign tgt_in_range = {1'b0, tgt} < (SEL_W + 1)'(CHANNELS);

  // Look up the target slot without indexing past the vector.
  always_comb begin
    tgt_full  = 1'b0;
    tgt_drain = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tgt == SEL_W'(i)) begin
        tgt_full  = full_vec[i];
        tgt_drain = y_ready[i];
      end
    end
  end

  // A full target that drains this edge can take a new word on the same edge.
  assign in_ready = rst_sync_reg & tgt_in_range & (~tgt_full | tgt_drain);
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_slot
      assign load_vec[gi] = accept & (tgt == SEL_W'(gi));

      demux_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk  (clk),
        .rst_n(rst_sync_reg),
        .load (load_vec[gi]),
        .data (d),
        .drain(y_ready[gi]),
        .full (full_vec[gi]),
        .q    (y[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // The scan pointer only moves on an auto-mode accept, so it parks on a
  // full channel (stall) and survives mode switches.
  always_comb begin
    scan_ptr_next = scan_ptr_reg;
    acc_cnt_next  = acc_cnt_reg;
    if (accept) begin
      acc_cnt_next = acc_cnt_reg + ACC_W'(1);
      if (mode_sel == MODE_AUTO_E) begin
        scan_ptr_next = (scan_ptr_reg == SEL_W'(CHANNELS - 1)) ? '0
                                                               : scan_ptr_reg + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg) begin
      scan_ptr_reg <= '0;
      acc_cnt_reg  <= '0;
    end else begin
      scan_ptr_reg <= scan_ptr_next;
      acc_cnt_reg  <= acc_cnt_next;
    end
  end

  assign y_valid = full_vec;
  assign cur_ch  = tgt;
  assign acc_cnt = acc_cnt_reg;

endmodule

// File: tb/tb_demux_nb_1_n_seq.sv
// tb_demux_nb_1_n_seq
// Drives a 4-channel/4-bit and a 3-channel/8-bit instance with identical
// stimulus and compares both against a behavioural model of the slots.
`include "demux_defs.vh"

module tb_demux_nb_1_n_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic [1:0] sel;
  logic [7:0] d8;
  logic [3:0] yr;

  logic        in_ready0, in_ready1;
  logic [15:0] y0;
  logic [23:0] y1;
  logic [3:0]  yv0;
  logic [2:0]  yv1;
  logic [1:0]  cur_ch0, cur_ch1;
  logic [7:0]  acc0, acc1;

  always #5 clk = ~clk;

  demux_nb_1_n_seq #(.WIDTH(4), .CHANNELS(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .d(d8[3:0]),
    .in_valid(in_valid), .in_ready(in_ready0), .y(y0), .y_valid(yv0),
    .y_ready(yr), .cur_ch(cur_ch0), .acc_cnt(acc0)
  );

  demux_nb_1_n_seq #(.WIDTH(8), .CHANNELS(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .d(d8),
    .in_valid(in_valid), .in_ready(in_ready1), .y(y1), .y_valid(yv1),
    .y_ready(yr[2:0]), .cur_ch(cur_ch1), .acc_cnt(acc1)
  );

  // Behavioural model, one entry per instance.
  int chn[2]   = '{4, 3};
  int wbits[2] = '{4, 8};
  int wmask[2] = '{15, 255};
  bit mfull[2][4];
  int mdata[2][4];
  int mptr[2];
  int mcnt[2];
  bit men;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        mfull[k][i] = 1'b0;
        mdata[k][i] = 0;
      end
      mptr[k] = 0;
      mcnt[k] = 0;
    end
    men = 1'b0;
  endtask

  function automatic int tgt_of(input int k);
    return (mode == `MODE_AUTO) ? mptr[k] : int'(sel);
  endfunction

  function automatic bit rdy_of(input int k, input int t);
    if (!men || t >= chn[k]) return 1'b0;
    return !mfull[k][t] || yr[t];
  endfunction

  task automatic check_state();
    logic [63:0] ey, ev;
    for (int k = 0; k < 2; k++) begin
      ey = '0;
      ev = '0;
      for (int i = 0; i < chn[k]; i++) begin
        ey = ey | (64'(mdata[k][i]) << (i * wbits[k]));
        ev = ev | (64'(mfull[k][i]) << i);
      end
      if (k == 0) begin
        chk("dut0 y", 64'(y0), ey);
        chk("dut0 y_valid", 64'(yv0), ev);
        chk("dut0 acc_cnt", 64'(acc0), 64'(mcnt[0]));
      end else begin
        chk("dut1 y", 64'(y1), ey);
        chk("dut1 y_valid", 64'(yv1), ev);
        chk("dut1 acc_cnt", 64'(acc1), 64'(mcnt[1]));
      end
    end
  endtask

  // One clock transaction: apply inputs, check the combinational handshake,
  // clock, advance the model, check the registered outputs.
  task automatic step(input bit m, input bit [1:0] s, input bit [7:0] dd,
                      input bit v, input bit [3:0] r);
    int t[2];
    bit acc[2];
    bit rdy;
    mode = m; sel = s; d8 = dd; in_valid = v; yr = r;
    #2;
    for (int k = 0; k < 2; k++) begin
      t[k]   = tgt_of(k);
      rdy    = rdy_of(k, t[k]);
      acc[k] = v && rdy;
      if (k == 0) begin
        chk("dut0 in_ready", 64'(in_ready0), 64'(rdy));
        chk("dut0 cur_ch", 64'(cur_ch0), 64'(t[k]));
      end else begin
        chk("dut1 in_ready", 64'(in_ready1), 64'(rdy));
        chk("dut1 cur_ch", 64'(cur_ch1), 64'(t[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < chn[k]; i++) begin
        if (acc[k] && t[k] == i) begin
          mfull[k][i] = 1'b1;
          mdata[k][i] = int'(dd) & wmask[k];
        end else if (mfull[k][i] && r[i]) begin
          mfull[k][i] = 1'b0;
        end
      end
      if (acc[k]) begin
        mcnt[k] = (mcnt[k] + 1) % 256;
        if (m) mptr[k] = (mptr[k] + 1) % chn[k];
      end
    end
    men = 1'b1;
    #1;
    check_state();
    $display("step mode=%0d sel=%0d d=%02h v=%0d yr=%b acc0=%0d acc1=%0d y0=%04h y1=%06h",
             m, s, dd, v, r, acc[0], acc[1], y0, y1);
  endtask

  task automatic check_reset_outputs();
    chk("rst dut0 in_ready", 64'(in_ready0), 64'd0);
    chk("rst dut1 in_ready", 64'(in_ready1), 64'd0);
    chk("rst dut0 cur_ch", 64'(cur_ch0), 64'(sel));
    check_state();
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = '0; d8 = '0; yr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // First edge after release cannot accept; manual sweep sel 0..3
    step(`MODE_MANUAL, 2'd0, 8'h05, 1'b1, 4'hF);
    for (int s = 0; s < 4; s++) step(`MODE_MANUAL, 2'(s), 8'h05, 1'b1, 4'hF);
    step(`MODE_MANUAL, 2'd0, 8'h00, 1'b0, 4'hF);

    // Backpressure on channel 2, then drain and load on the same edge
    step(`MODE_MANUAL, 2'd2, 8'h0A, 1'b1, 4'h0);
    step(`MODE_MANUAL, 2'd2, 8'h0B, 1'b1, 4'h0);
    step(`MODE_MANUAL, 2'd2, 8'h0B, 1'b1, 4'b0100);
    step(`MODE_MANUAL, 2'd2, 8'h00, 1'b0, 4'h0);
    step(`MODE_MANUAL, 2'd0, 8'h00, 1'b0, 4'hF);

    // Out-of-range target on the 3-channel instance
    step(`MODE_MANUAL, 2'd3, 8'h77, 1'b1, 4'hF);

    // Auto-scan, six words
    for (int w = 1; w <= 6; w++) step(`MODE_AUTO, 2'd0, 8'(w), 1'b1, 4'hF);

    // Auto stall on a full channel 1, then release
    for (int j = 0; j < 9; j++) step(`MODE_AUTO, 2'd0, 8'(8'h10 + j), 1'b1, 4'b1101);
    for (int j = 0; j < 3; j++) step(`MODE_AUTO, 2'd0, 8'(8'h30 + j), 1'b1, 4'hF);

    // Reset mid-operation with two full channels and a word in flight
    step(`MODE_MANUAL, 2'd0, 8'hC3, 1'b1, 4'h0);
    step(`MODE_MANUAL, 2'd1, 8'h5A, 1'b1, 4'h0);
    #2;
    mode = `MODE_MANUAL; sel = 2'd0; in_valid = 1'b1; d8 = 8'hEE;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(`MODE_MANUAL, 2'd0, 8'hEE, 1'b1, 4'h0);
    step(`MODE_MANUAL, 2'd0, 8'hEE, 1'b1, 4'h0);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
           ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
